// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues fetches, queues {pc, instruction} pairs for decode.
// Latency: first request 1 cycle after reset release or redirect; instruction valid 2 cycles after its request.
// Backpressure: stall freezes the head; fetch continues until queued + outstanding reach DEPTH.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   branch_taken/target  redirect from EX (flushes queue and outstanding response)
//   stall                decode cannot accept the head this cycle
//   imem_req/addr        registered read strobe/address to 1-cycle synchronous instruction memory
//   imem_rdata           read data, valid the cycle after imem_req
//   pc/instruction       head entry shown to decode (hold last value while empty)
//   instr_valid          head entry valid
//   fifo_level           occupied queue entries
module if_prefetch_stage #(
  parameter int                 ADDR_W   = 19,
  parameter int                 INSTR_W  = 19,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          branch_taken,
  input  logic [ADDR_W-1:0]             branch_target,
  input  logic                          stall,
  output logic                          imem_req,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [INSTR_W-1:0]            imem_rdata,
  output logic [ADDR_W-1:0]             pc,
  output logic [INSTR_W-1:0]            instruction,
  output logic                          instr_valid,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,  // issuing normally
    FULL     = 2'd1,  // credit exhausted, no request this cycle
    REDIRECT = 2'd2   // first cycle after a branch, queue known empty
  } state_t;

  state_t               state;
  logic [ADDR_W-1:0]    fetch_pc;
  logic                 inflight;   // imem_rdata carries a response this cycle
  logic                 drop;       // that response belongs to a flushed path
  logic [ADDR_W-1:0]    rsp_pc;     // address of the response in imem_rdata

  logic [ADDR_W-1:0]    pc_mem  [DEPTH];
  logic [INSTR_W-1:0]   ins_mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [LVL_W-1:0]     level;

  // Last value shown to decode, used while the queue is empty.
  logic [ADDR_W-1:0]    pc_hold;
  logic [INSTR_W-1:0]   ins_hold;

  logic                 head_vld;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic [LVL_W:0]       credit_use;

  assign head_vld    = (level != '0);
  assign instr_valid = head_vld;
  assign fifo_level  = level;
  assign pc          = head_vld ? pc_mem[rd_ptr]  : pc_hold;
  assign instruction = head_vld ? ins_mem[rd_ptr] : ins_hold;

  // A branch overrides every other queue operation in its cycle.
  assign pop  = head_vld && !stall && !branch_taken;
  assign push = inflight && !drop && !branch_taken;

  // Entries held + responses still owed (data now, request now) minus the
  // entry leaving this cycle; a new request needs one free slot beyond that.
  assign credit_use = (LVL_W+1)'(level) + (LVL_W+1)'(inflight)
                    + (LVL_W+1)'(imem_req) - (LVL_W+1)'(pop);

  // Right after a redirect the queue is empty and the only response still owed
  // is being dropped, so a request is always safe.
  assign issue = !branch_taken &&
                 ((state == REDIRECT) || (credit_use < (LVL_W+1)'(DEPTH)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      inflight  <= 1'b0;
      drop      <= 1'b0;
      rsp_pc    <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      pc_hold   <= '0;
      ins_hold  <= '0;
    end else begin
      pc_hold  <= pc;
      ins_hold <= instruction;
      inflight <= imem_req;
      rsp_pc   <= imem_addr;

      if (branch_taken) begin
        state    <= REDIRECT;
        fetch_pc <= branch_target;
        imem_req <= 1'b0;
        // A request out this cycle answers next cycle on the old path.
        drop     <= imem_req;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        level    <= '0;
      end else begin
        drop <= 1'b0;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        level <= level + LVL_W'(push) - LVL_W'(pop);

        if (issue) begin
          state     <= RUN;
          imem_req  <= 1'b1;
          imem_addr <= fetch_pc;
          fetch_pc  <= fetch_pc + ADDR_W'(1);
        end else begin
          state    <= FULL;
          imem_req <= 1'b0;
        end
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by level/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= rsp_pc;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (level == LVL_W'(DEPTH))));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed timing scenarios plus a randomized
// stall/branch run checked against an in-order instruction-stream model.
// A second instance with a 4-bit address exercises PC wrap-around.
module tb_if_prefetch_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic [18:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [18:0] imem_addr;
  logic [18:0] imem_rdata = '0;
  logic [18:0] pc;
  logic [18:0] instruction;
  logic        instr_valid;
  logic [2:0]  fifo_level;

  logic        branch_w = 1'b0;
  logic [3:0]  target_w = '0;
  logic        req_w;
  logic [3:0]  addr_w;
  logic [18:0] rdata_w = '0;
  logic [3:0]  pc_w;
  logic [18:0] instr_w;
  logic        valid_w;
  logic [2:0]  level_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_prefetch_stage #(.ADDR_W(19), .INSTR_W(19), .DEPTH(DEPTH), .RESET_PC('0)) u_dut (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .instruction(instruction), .instr_valid(instr_valid), .fifo_level(fifo_level)
  );

  if_prefetch_stage #(.ADDR_W(4), .INSTR_W(19), .DEPTH(DEPTH), .RESET_PC('0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_w), .branch_target(target_w),
    .stall(stall), .imem_req(req_w), .imem_addr(addr_w), .imem_rdata(rdata_w),
    .pc(pc_w), .instruction(instr_w), .instr_valid(valid_w), .fifo_level(level_w)
  );

  function automatic logic [18:0] mdata(input logic [31:0] a);
    return 19'(32'h10000 + a);
  endfunction

  // 1-cycle synchronous instruction memories.
  always @(posedge clk) if (imem_req) imem_rdata <= mdata(32'(imem_addr));
  always @(posedge clk) if (req_w)    rdata_w    <= mdata(32'(addr_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input string tag, input int lvl);
    int n = 0;
    while (32'(fifo_level) != lvl && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(fifo_level), lvl);
  endtask

  // Two reset cycles, release, then three cycles until the first instruction.
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  // Branch and check the redirect timeline: empty, request target, stale
  // response dropped, target valid three cycles after the branch cycle.
  task automatic do_branch(input string tag, input logic [18:0] tgt);
    branch_taken  = 1'b1;
    branch_target = tgt;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    check({tag, "_b0_vld"}, 32'(instr_valid), 0);
    check({tag, "_b0_lvl"}, 32'(fifo_level), 0);
    check({tag, "_b0_req"}, 32'(imem_req), 0);
    tick();
    check({tag, "_b1_req"}, 32'(imem_req), 1);
    check({tag, "_b1_addr"}, 32'(imem_addr), 32'(tgt));
    check({tag, "_b1_vld"}, 32'(instr_valid), 0);
    tick();
    check({tag, "_b2_vld"}, 32'(instr_valid), 0);
    tick();
    check({tag, "_b3_vld"}, 32'(instr_valid), 1);
    check({tag, "_b3_pc"}, 32'(pc), 32'(tgt));
    check({tag, "_b3_ins"}, 32'(instruction), 32'(mdata(32'(tgt))));
    tick();
    check({tag, "_b4_pc"}, 32'(pc), 32'(19'(tgt + 19'd1)));
    check({tag, "_b4_vld"}, 32'(instr_valid), 1);
  endtask

  initial begin
    logic [18:0] exp_pc;
    logic [18:0] first_pc;
    int          seen50;
    int          full_req;
    int          got_first;
    int          delivered;
    logic        br;
    logic [18:0] tgt;

    // Reset then stream.
    tick();
    tick();
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_ins", 32'(instruction), 0);
    check("rst_vld", 32'(instr_valid), 0);
    check("rst_lvl", 32'(fifo_level), 0);
    rst_n = 1'b1;
    tick();
    check("s_first_req", 32'(imem_req), 1);
    check("s_first_addr", 32'(imem_addr), 0);
    check("s_e1_vld", 32'(instr_valid), 0);
    tick();
    check("s_e2_vld", 32'(instr_valid), 0);
    tick();
    check("s_e3_vld", 32'(instr_valid), 1);
    check("s_e3_pc", 32'(pc), 0);
    check("s_e3_ins", 32'(instruction), 32'h10000);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("s_pc", 32'(pc), i);
      check("s_ins", 32'(instruction), 32'h10000 + i);
      check("s_vld", 32'(instr_valid), 1);
      check("s_lvl_le1", 32'(fifo_level <= 3'd1), 1);
    end

    // Stall fill and drain.
    do_reset();
    check("f_vld0", 32'(instr_valid), 1);
    stall    = 1'b1;
    full_req = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("f_hold_pc", 32'(pc), 0);
      if (fifo_level == 3'd4 && imem_req) full_req++;
    end
    check("f_full_lvl", 32'(fifo_level), 4);
    check("f_full_noreq", 32'(full_req), 0);
    stall = 1'b0;
    tick();
    check("f_resume_req", 32'(imem_req), 1);
    check("f_resume_addr", 32'(imem_addr), 4);
    check("f_drain_pc1", 32'(pc), 1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("f_drain_pc", 32'(pc), i);
      check("f_drain_vld", 32'(instr_valid), 1);
    end

    // Branch flush with a partly full queue, then during free streaming.
    stall = 1'b1;
    wait_level("br_lvl3", 3);
    do_branch("brA", 19'd138);
    do_branch("brB", 19'd90);

    // Back-to-back branches while stalled: only the last target is fetched.
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 19'd50;
    tick();
    branch_target = 19'd200;
    tick();
    branch_taken = 1'b0;
    seen50    = 0;
    got_first = 0;
    first_pc  = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (instr_valid && pc == 19'd50) seen50++;
      if (instr_valid && got_first == 0) begin
        got_first = 1;
        first_pc  = pc;
      end
    end
    check("bb_no50", 32'(seen50), 0);
    check("bb_got", 32'(got_first), 1);
    check("bb_first", 32'(first_pc), 200);
    stall = 1'b0;
    tick();
    check("bb_next", 32'(pc), 201);

    // Address wrap-around on the 4-bit instance.
    branch_w = 1'b1;
    target_w = 4'd14;
    tick();
    branch_w = 1'b0;
    tick();
    tick();
    tick();
    check("w_pc14", 32'(pc_w), 14);
    tick();
    check("w_pc15", 32'(pc_w), 15);
    tick();
    check("w_pc0", 32'(pc_w), 0);
    check("w_ins0", 32'(instr_w), 32'h10000);
    tick();
    check("w_pc1", 32'(pc_w), 1);
    check("w_vld", 32'(valid_w), 1);

    // Reset with a full queue.
    stall = 1'b1;
    wait_level("mr_full", 4);
    rst_n = 1'b0;
    tick();
    check("mr_req", 32'(imem_req), 0);
    check("mr_addr", 32'(imem_addr), 0);
    check("mr_pc", 32'(pc), 0);
    check("mr_ins", 32'(instruction), 0);
    check("mr_vld", 32'(instr_valid), 0);
    check("mr_lvl", 32'(fifo_level), 0);
    rst_n = 1'b1;
    stall = 1'b0;
    tick();
    check("mr_req1", 32'(imem_req), 1);
    check("mr_addr1", 32'(imem_addr), 0);
    tick();
    tick();
    check("mr_vld3", 32'(instr_valid), 1);
    check("mr_pc3", 32'(pc), 0);

    // Random stall/branch traffic: decode must see an unbroken in-order stream
    // starting from the latest redirect target.
    exp_pc    = '0;
    delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      br    = ($urandom_range(0, 99) < 5);
      tgt   = 19'($urandom);
      branch_taken  = br;
      branch_target = tgt;
      if (br) begin
        exp_pc = tgt;
      end else if (instr_valid && !stall) begin
        check("rnd_pc", 32'(pc), 32'(exp_pc));
        check("rnd_ins", 32'(instruction), 32'(mdata(32'(exp_pc))));
        exp_pc = exp_pc + 19'd1;
        delivered++;
      end
      tick();
      check("rnd_lvl_max", 32'(fifo_level <= 3'(DEPTH)), 1);
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
    check("rnd_progress", 32'(delivered > 400), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
